id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register plus execute-stage operand selection.
- Captures decoded operands and control signals each cycle.
- Resolves data forwarding from the MEM and WB stages.
- Drives SrcA, SrcB and ALUControl directly into the ALU. Also carries store data and control bits on to the EX/MEM stage.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/operand_fwd_mux.sv | 23 ++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, forwarding selects and ALU opcodes.
// Used by the ID/EX stage and its operand forwarding muxes.
package cpu_pkg;

  localparam int DATA_WIDTH_DEF       = 32;
  localparam int ALU_CTRL_WIDTH_DEF   = 4;
  localparam int REG_ADDR_WIDTH_DEF   = 5;
  localparam int RESULT_SRC_WIDTH_DEF = 2;

  // Encoding 2'b11 is reserved and falls back to the register value.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX stage.
// master = decode/hazard side driving the stage, slave = the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALU_CTRL_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULT_SRC_WIDTH = 2
);

  logic                        StallE, FlushE;
  logic [DATA_WIDTH-1:0]       RD1D, RD2D, PCD, ImmExtD;
  logic [REG_ADDR_WIDTH-1:0]   Rs1D, Rs2D, RdD;
  logic [ALU_CTRL_WIDTH-1:0]   ALUControlD;
  logic                        ALUSrcAD, ALUSrcBD;
  logic                        RegWriteD, MemWriteD, BranchD, JumpD;
  logic [RESULT_SRC_WIDTH-1:0] ResultSrcD;
  logic [1:0]                  ForwardAE, ForwardBE;
  logic [DATA_WIDTH-1:0]       ALUResultM, ResultW;

  logic [DATA_WIDTH-1:0]       SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [ALU_CTRL_WIDTH-1:0]   ALUControlE;
  logic [REG_ADDR_WIDTH-1:0]   Rs1E, Rs2E, RdE;
  logic                        RegWriteE, MemWriteE, BranchE, JumpE;
  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE;

  modport master (
    output StallE, FlushE, RD1D, RD2D, PCD, ImmExtD, Rs1D, Rs2D, RdD,
           ALUControlD, ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, BranchD,
           JumpD, ResultSrcD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E,
           RdE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE
  );

  modport slave (
    input  StallE, FlushE, RD1D, RD2D, PCD, ImmExtD, Rs1D, Rs2D, RdD,
           ALUControlD, ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, BranchD,
           JumpD, ResultSrcD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    output SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E,
           RdE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// 3:1 operand forwarding mux: register value, WB result or MEM ALU result.
module operand_fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic [DATA_WIDTH-1:0] result_w,
  input  logic [DATA_WIDTH-1:0] alu_result_m,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    case (fwd_sel_t'(sel))
      FWD_W:   fwd_data = result_w;
      FWD_M:   fwd_data = alu_result_m;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with forwarding and ALU operand selection.
// Reset and flush both load a bubble; stall freezes the registers only.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int ALU_CTRL_WIDTH   = ALU_CTRL_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
  parameter int RESULT_SRC_WIDTH = RESULT_SRC_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  logic [DATA_WIDTH-1:0]       rd1_reg, rd2_reg, pc_reg, imm_reg;
  logic [REG_ADDR_WIDTH-1:0]   rs1_reg, rs2_reg, rd_reg;
  logic [ALU_CTRL_WIDTH-1:0]   alu_ctrl_reg;
  logic                        alu_src_a_reg, alu_src_b_reg;
  logic                        reg_write_reg, mem_write_reg, branch_reg, jump_reg;
  logic [RESULT_SRC_WIDTH-1:0] result_src_reg;

  always_ff @(posedge clk) begin
    if (rst || bus.FlushE) begin
      rd1_reg        <= '0;
      rd2_reg        <= '0;
      pc_reg         <= '0;
      imm_reg        <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      alu_ctrl_reg   <= ALU_CTRL_WIDTH'(ALU_ADD);
      alu_src_a_reg  <= 1'b0;
      alu_src_b_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_write_reg  <= 1'b0;
      branch_reg     <= 1'b0;
      jump_reg       <= 1'b0;
      result_src_reg <= '0;
    end else if (!bus.StallE) begin
      rd1_reg        <= bus.RD1D;
      rd2_reg        <= bus.RD2D;
      pc_reg         <= bus.PCD;
      imm_reg        <= bus.ImmExtD;
      rs1_reg        <= bus.Rs1D;
      rs2_reg        <= bus.Rs2D;
      rd_reg         <= bus.RdD;
      alu_ctrl_reg   <= bus.ALUControlD;
      alu_src_a_reg  <= bus.ALUSrcAD;
      alu_src_b_reg  <= bus.ALUSrcBD;
      // A write to x0 is dropped here so downstream never sees it.
      reg_write_reg  <= bus.RegWriteD && (bus.RdD != '0);
      mem_write_reg  <= bus.MemWriteD;
      branch_reg     <= bus.BranchD;
      jump_reg       <= bus.JumpD;
      result_src_reg <= bus.ResultSrcD;
    end
  end

  // Index 0 forwards operand A (rs1), index 1 forwards operand B (rs2).
  logic [1:0]            fwd_sel  [2];
  logic [DATA_WIDTH-1:0] reg_data [2];
  logic [DATA_WIDTH-1:0] fwd_data [2];

  assign fwd_sel[0]  = bus.ForwardAE;
  assign fwd_sel[1]  = bus.ForwardBE;
  assign reg_data[0] = rd1_reg;
  assign reg_data[1] = rd2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      operand_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_mux (
        .sel          (fwd_sel[gi]),
        .reg_data     (reg_data[gi]),
        .result_w     (bus.ResultW),
        .alu_result_m (bus.ALUResultM),
        .fwd_data     (fwd_data[gi])
      );
    end
  endgenerate

  assign bus.SrcAE       = alu_src_a_reg ? pc_reg  : fwd_data[0];
  assign bus.SrcBE       = alu_src_b_reg ? imm_reg : fwd_data[1];
  assign bus.WriteDataE  = fwd_data[1];
  assign bus.PCE         = pc_reg;
  assign bus.ImmExtE     = imm_reg;
  assign bus.ALUControlE = alu_ctrl_reg;
  assign bus.Rs1E        = rs1_reg;
  assign bus.Rs2E        = rs2_reg;
  assign bus.RdE         = rd_reg;
  assign bus.RegWriteE   = reg_write_reg;
  assign bus.MemWriteE   = mem_write_reg;
  assign bus.BranchE     = branch_reg;
  assign bus.JumpE       = jump_reg;
  assign bus.ResultSrcE  = result_src_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps followed by random
// traffic, checked against an instruction-record model of the E stage.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: the E stage holds one decoded instruction record (or a bubble).
  typedef struct {
    logic [31:0] rd1, rd2, pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        srca, srcb, rw, mw, br, jp;
    logic [1:0]  rsrc;
  } instr_t;

  instr_t e_model;
  int compared   = 0;
  int mismatched = 0;

  function automatic instr_t bubble();
    instr_t b;
    b.rd1 = 0; b.rd2 = 0; b.pc = 0; b.imm = 0;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.alu = 0;
    b.srca = 0; b.srcb = 0; b.rw = 0; b.mw = 0; b.br = 0; b.jp = 0;
    b.rsrc = 0;
    return b;
  endfunction

  function automatic instr_t decoded();
    instr_t d;
    d.rd1 = bus.RD1D; d.rd2 = bus.RD2D; d.pc = bus.PCD; d.imm = bus.ImmExtD;
    d.rs1 = bus.Rs1D; d.rs2 = bus.Rs2D; d.rd = bus.RdD; d.alu = bus.ALUControlD;
    d.srca = bus.ALUSrcAD; d.srcb = bus.ALUSrcBD;
    d.rw = bus.RegWriteD & (bus.RdD != 0);
    d.mw = bus.MemWriteD; d.br = bus.BranchD; d.jp = bus.JumpD;
    d.rsrc = bus.ResultSrcD;
    return d;
  endfunction

  // Value of an operand after forwarding: 1 -> WB, 2 -> MEM, else register.
  function automatic logic [31:0] operand(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'd1) return bus.ResultW;
    if (sel == 2'd2) return bus.ALUResultM;
    return regv;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] a, b;
    a = operand(bus.ForwardAE, e_model.rd1);
    b = operand(bus.ForwardBE, e_model.rd2);
    chk({tag, ".SrcAE"},      bus.SrcAE,       e_model.srca ? e_model.pc : a);
    chk({tag, ".SrcBE"},      bus.SrcBE,       e_model.srcb ? e_model.imm : b);
    chk({tag, ".WriteDataE"}, bus.WriteDataE,  b);
    chk({tag, ".PCE"},        bus.PCE,         e_model.pc);
    chk({tag, ".ImmExtE"},    bus.ImmExtE,     e_model.imm);
    chk({tag, ".ALUControlE"}, 32'(bus.ALUControlE), 32'(e_model.alu));
    chk({tag, ".Rs1E"},       32'(bus.Rs1E),   32'(e_model.rs1));
    chk({tag, ".Rs2E"},       32'(bus.Rs2E),   32'(e_model.rs2));
    chk({tag, ".RdE"},        32'(bus.RdE),    32'(e_model.rd));
    chk({tag, ".RegWriteE"},  32'(bus.RegWriteE), 32'(e_model.rw));
    chk({tag, ".MemWriteE"},  32'(bus.MemWriteE), 32'(e_model.mw));
    chk({tag, ".BranchE"},    32'(bus.BranchE),   32'(e_model.br));
    chk({tag, ".JumpE"},      32'(bus.JumpE),     32'(e_model.jp));
    chk({tag, ".ResultSrcE"}, 32'(bus.ResultSrcE), 32'(e_model.rsrc));
  endtask

  // One clock: advance the model at the edge, then settle before checks.
  task automatic tick();
    @(posedge clk);
    if (rst || bus.FlushE) e_model = bubble();
    else if (!bus.StallE)  e_model = decoded();
    #1;
  endtask

  task automatic rand_d();
    bus.RD1D = $urandom; bus.RD2D = $urandom;
    bus.PCD = $urandom; bus.ImmExtD = $urandom;
    bus.Rs1D = 5'($urandom); bus.Rs2D = 5'($urandom);
    bus.RdD = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    bus.ALUControlD = 4'($urandom_range(0, 9));
    bus.ALUSrcAD = 1'($urandom); bus.ALUSrcBD = 1'($urandom);
    bus.RegWriteD = 1'($urandom); bus.MemWriteD = 1'($urandom);
    bus.BranchD = 1'($urandom); bus.JumpD = 1'($urandom);
    bus.ResultSrcD = 2'($urandom);
  endtask

  task automatic rand_fwd();
    bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
    bus.ALUResultM = $urandom; bus.ResultW = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    bus.StallE = 0; bus.FlushE = 0;
    rand_d();
    bus.RegWriteD = 1; bus.RdD = 5'd7; bus.ALUControlD = 4'd5; bus.MemWriteD = 1;
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ALUResultM = 0; bus.ResultW = 0;

    // Reset with nonzero decode inputs.
    tick(); tick();
    chk("rst_alu", 32'(bus.ALUControlE), 32'h0);
    chk("rst_regwrite", 32'(bus.RegWriteE), 32'h0);
    chk("rst_srca", bus.SrcAE, 32'h0);
    chk("rst_rd", 32'(bus.RdE), 32'h0);
    check_all("rst");
    rst = 1'b0;

    // Plain load and forwarding.
    bus.RD1D = 32'h10; bus.RD2D = 32'h20; bus.ALUSrcAD = 0; bus.ALUSrcBD = 0;
    tick();
    chk("load_srca", bus.SrcAE, 32'h10);
    chk("load_srcb", bus.SrcBE, 32'h20);
    check_all("load");
    bus.ForwardAE = 2'b10; bus.ALUResultM = 32'hDEAD; #1;
    chk("fwdm_srca", bus.SrcAE, 32'hDEAD);
    bus.ForwardBE = 2'b01; bus.ResultW = 32'h55; #1;
    chk("fwdw_srcb", bus.SrcBE, 32'h55);
    chk("fwdw_wdata", bus.WriteDataE, 32'h55);
    check_all("fwd");

    // PC / immediate operand select.
    bus.ForwardAE = 0; bus.ForwardBE = 0;
    bus.ALUSrcAD = 1; bus.ALUSrcBD = 1;
    bus.PCD = 32'h100; bus.ImmExtD = 32'h4; bus.RD2D = 32'h77;
    tick();
    chk("sel_srca", bus.SrcAE, 32'h100);
    chk("sel_srcb", bus.SrcBE, 32'h4);
    chk("sel_wdata", bus.WriteDataE, 32'h77);

    // Stall holds instruction X, then flush+stall yields a bubble.
    bus.ALUSrcAD = 0; bus.ALUSrcBD = 0; bus.RD1D = 32'hAAAA;
    bus.RdD = 5'd5; bus.RegWriteD = 1; bus.MemWriteD = 1;
    tick();
    bus.StallE = 1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      bus.RdD = 5'd9;
      tick();
      chk("stall_rd", 32'(bus.RdE), 32'd5);
      chk("stall_srca", bus.SrcAE, 32'hAAAA);
      chk("stall_rw", 32'(bus.RegWriteE), 32'd1);
    end
    bus.FlushE = 1;
    tick();
    chk("flush_rw", 32'(bus.RegWriteE), 32'd0);
    chk("flush_mw", 32'(bus.MemWriteE), 32'd0);
    chk("flush_rd", 32'(bus.RdE), 32'd0);
    check_all("flush");
    bus.FlushE = 0; bus.StallE = 0;

    // x0 guard on RegWrite.
    bus.RegWriteD = 1; bus.RdD = 5'd0;
    tick();
    chk("x0_rw", 32'(bus.RegWriteE), 32'd0);
    bus.RdD = 5'd1;
    tick();
    chk("x1_rw", 32'(bus.RegWriteE), 32'd1);

    // Reserved forwarding select falls back to the register.
    bus.RD1D = 32'h12; bus.ALUSrcAD = 0;
    tick();
    bus.ForwardAE = 2'b11; bus.ALUResultM = 32'h34; bus.ResultW = 32'h56; #1;
    chk("rsvd_srca", bus.SrcAE, 32'h12);

    // Reset during a stall still clears.
    bus.StallE = 1; rst = 1;
    tick();
    chk("rst_stall_rd", 32'(bus.RdE), 32'd0);
    chk("rst_stall_rw", 32'(bus.RegWriteE), 32'd0);
    rst = 0; bus.StallE = 0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      bus.StallE = ($urandom_range(0, 3) == 0);
      bus.FlushE = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 29) == 0);
      tick();
      rand_fwd(); #1;
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
